// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One radix-2 step per cycle: shift-add for MULT/MULTU, restoring division for DIV/DIVU.
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   start_i, op_i          launch (accepted when not busy); 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_i, rt_i             multiplicand/dividend, multiplier/divisor
//   flush_i                abort the in-flight operation
//   hi_we_i, lo_we_i       MTHI/MTLO writes of wdata_i (honoured only when not busy)
//   busy_o, done_o, dbz_o  status; done_o and dbz_o pulse when an operation updates HI/LO
//   hi_o, lo_o             HI/LO registers
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             flush_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             dbz_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q, dbz_q, sign_diff_q, rem_neg_q;
  logic [WIDTH-1:0] opnd_q, acc_hi_q, acc_lo_q;

  logic             launch_c, rs_neg_c, rt_neg_c, start_dbz_c;
  logic [WIDTH-1:0] rs_mag_c, rt_mag_c;
  logic [WIDTH:0]   mul_sum_c, div_sh_c;
  logic             div_ge_c;
  logic [WIDTH-1:0] div_diff_c, iter_hi_c, iter_lo_c;
  logic [PW-1:0]    prod_c, prod_fix_c;
  logic [WIDTH-1:0] quot_fix_c, rem_fix_c, fix_hi_c, fix_lo_c;

  // Operand capture: magnitudes for signed ops, divide-by-zero detection.
  always_comb begin
    launch_c    = start_i && (state_q == S_IDLE || state_q == S_DONE);
    rs_neg_c    = ~op_i[0] & rs_i[WIDTH-1];
    rt_neg_c    = ~op_i[0] & rt_i[WIDTH-1];
    rs_mag_c    = rs_neg_c ? (~rs_i + WIDTH'(1)) : rs_i;
    rt_mag_c    = rt_neg_c ? (~rt_i + WIDTH'(1)) : rt_i;
    start_dbz_c = op_i[1] && (rt_i == '0);
  end

  // One iteration. Multiply: acc_lo holds the multiplier and shifts out as the product
  // shifts in. Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
  always_comb begin
    mul_sum_c  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_sh_c   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge_c   = div_sh_c >= {1'b0, opnd_q};
    div_diff_c = WIDTH'(div_sh_c - {1'b0, opnd_q});
    if (is_div_q) begin
      iter_hi_c = div_ge_c ? div_diff_c : div_sh_c[WIDTH-1:0];
      iter_lo_c = {acc_lo_q[WIDTH-2:0], div_ge_c};
    end else begin
      iter_hi_c = mul_sum_c[WIDTH:1];
      iter_lo_c = {mul_sum_c[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  // Sign correction. Most-negative / -1 needs no special case: the negated
  // quotient magnitude 2^(W-1) is the most-negative value itself.
  always_comb begin
    prod_c     = {acc_hi_q, acc_lo_q};
    prod_fix_c = sign_diff_q ? (~prod_c + PW'(1)) : prod_c;
    quot_fix_c = sign_diff_q ? (~acc_lo_q + WIDTH'(1)) : acc_lo_q;
    rem_fix_c  = rem_neg_q ? (~acc_hi_q + WIDTH'(1)) : acc_hi_q;
    if (dbz_q) begin
      fix_hi_c = acc_hi_q;
      fix_lo_c = '1;
    end else if (is_div_q) begin
      fix_hi_c = rem_fix_c;
      fix_lo_c = quot_fix_c;
    end else begin
      fix_hi_c = prod_fix_c[PW-1:WIDTH];
      fix_lo_c = prod_fix_c[WIDTH-1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) state_d = start_dbz_c ? S_FIX : S_CALC;
        else         state_d = S_IDLE;
      end
      S_CALC: begin
        if (flush_i)                state_d = S_IDLE;
        else if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX:   state_d = flush_i ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register and status flags, registered from the next state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      dbz_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_o  <= (state_d == S_CALC) || (state_d == S_FIX);
      done_o  <= (state_d == S_DONE);
      dbz_o   <= (state_d == S_DONE) && dbz_q;
    end
  end

  // Iteration counter; returns to zero whenever CALC is left.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                         cnt_q <= '0;
    else if (state_q == S_CALC && state_d == S_CALC)   cnt_q <= cnt_q + CNT_W'(1);
    else                                               cnt_q <= '0;
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      is_div_q    <= 1'b0;
      dbz_q       <= 1'b0;
      sign_diff_q <= 1'b0;
      rem_neg_q   <= 1'b0;
      opnd_q      <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
    end else if (launch_c) begin
      is_div_q    <= op_i[1];
      dbz_q       <= start_dbz_c;
      sign_diff_q <= rs_neg_c ^ rt_neg_c;
      rem_neg_q   <= rs_neg_c;
      if (op_i[1]) begin
        opnd_q   <= rt_mag_c;
        acc_hi_q <= start_dbz_c ? rs_i : '0;
        acc_lo_q <= rs_mag_c;
      end else begin
        opnd_q   <= rs_mag_c;
        acc_hi_q <= '0;
        acc_lo_q <= rt_mag_c;
      end
    end else if (state_q == S_CALC) begin
      acc_hi_q <= iter_hi_c;
      acc_lo_q <= iter_lo_c;
    end
  end

  // HI/LO: MTHI/MTLO while idle, result writeback from FIX unless flushed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (!busy_o) begin
      if (hi_we_i) hi_o <= wdata_i;
      if (lo_we_i) lo_o <= wdata_i;
    end else if (state_q == S_FIX && !flush_i) begin
      hi_o <= fix_hi_c;
      lo_o <= fix_lo_c;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: constant vector table, model-checked random
// operations, and hand-written sequences for flush, reset, MTHI/MTLO and WIDTH=8.
module tb_muldiv_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst, start, flush, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] rs, rt, wdata;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  logic         start8;
  logic [1:0]   op8;
  logic [7:0]   rs8, rt8, hi8, lo8;
  logic         busy8, done8, dbz8;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .rs_i(rs), .rt_i(rt),
    .flush_i(flush), .hi_we_i(hi_we), .lo_we_i(lo_we), .wdata_i(wdata),
    .busy_o(busy), .done_o(done), .dbz_o(dbz), .hi_o(hi), .lo_o(lo)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .op_i(op8), .rs_i(rs8), .rt_i(rt8),
    .flush_i(1'b0), .hi_we_i(1'b0), .lo_we_i(1'b0), .wdata_i(8'h00),
    .busy_o(busy8), .done_o(done8), .dbz_o(dbz8), .hi_o(hi8), .lo_o(lo8)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] rs, rt, hi, lo;
    logic         dbz;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi, lo;
    logic         dbz;
    int           lat;
  } exp_t;

  vec_t         tbl [12];
  exp_t         sbq [$];
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] hi_c1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference results from native wide arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    longint      x, y, q, r;
    logic [63:0] p;
    e.dbz = 1'b0;
    e.lat = W + 2;
    x = longint'($signed(a));
    y = longint'($signed(b));
    if (o[1] && b == '0) begin
      e.hi = a; e.lo = '1; e.dbz = 1'b1; e.lat = 2;
    end else begin
      case (o)
        2'b00: begin p = 64'(x * y); e.hi = p[63:32]; e.lo = p[31:0]; end
        2'b01: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
        2'b10: begin q = x / y; r = x % y; e.lo = 32'(q); e.hi = 32'(r); end
        default: begin e.lo = a / b; e.hi = a % b; end
      endcase
    end
    return e;
  endfunction

  // Drive a launch at the current negedge and push its expected result.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    op = o; rs = a; rt = b; start = 1'b1;
    sbq.push_back(e);
  endtask

  // Wait (bounded) for done_o, checking busy_o, latency and the popped expectation.
  task automatic wait_done(input string name);
    exp_t e;
    int   n;
    bit   busy_ok;
    n = 0; busy_ok = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        hi_c1 = hi;
      end
      if (done) begin n = i; break; end
      if (!busy) busy_ok = 1'b0;
    end
    e = sbq.pop_front();
    check({name, " latency"}, 64'(n), 64'(e.lat));
    check({name, " busy before done"}, 64'(busy_ok), 64'(1));
    check({name, " busy/dbz at done"}, {62'b0, busy, dbz}, {62'b0, 1'b0, e.dbz});
    check({name, " hi"}, 64'(hi), 64'(e.hi));
    check({name, " lo"}, 64'(lo), 64'(e.lo));
  endtask

  initial begin
    int           dn, dcyc;
    logic [W-1:0] hv, lv, hb, lb;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;

    tbl[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    tbl[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    tbl[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    tbl[3]  = '{2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
    tbl[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    tbl[5]  = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    tbl[6]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    tbl[7]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    tbl[8]  = '{2'b01, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 1'b0};
    tbl[9]  = '{2'b10, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1};
    tbl[10] = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
    tbl[11] = '{2'b00, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0};

    rst = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; rs = '0; rt = '0; wdata = '0;
    start8 = 1'b0; op8 = 2'b00; rs8 = 8'h00; rt8 = 8'h00;
    repeat (2) @(negedge clk);
    check("reset hi/lo", {hi, lo}, 64'h0);
    check("reset flags", {61'b0, busy, done, dbz}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors, issued back-to-back in each DONE cycle.
    for (int i = 0; i < 12; i++) begin
      issue(tbl[i].op, tbl[i].rs, tbl[i].rt,
            '{tbl[i].hi, tbl[i].lo, tbl[i].dbz, (tbl[i].dbz ? 2 : W + 2)});
      wait_done($sformatf("vec%0d", i));
    end

    // Random operations against the model.
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
      issue(ro, ra, rb, model(ro, ra, rb));
      wait_done($sformatf("rnd%0d", i));
    end

    // MTHI, then MULT flushed in cycle 10.
    hi_we = 1'b1; wdata = 32'h00001234;
    @(negedge clk); hi_we = 1'b0;
    check("mthi", 64'(hi), 64'h1234);
    lb = lo;
    op = 2'b00; rs = 32'd7; rt = 32'd9; start = 1'b1;
    @(posedge clk);
    dn = 0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 10) flush = 1'b1;
      if (i == 11) begin flush = 1'b0; check("flush busy drop", 64'(busy), 64'(0)); end
      if (done) dn++;
    end
    check("flush no done", 64'(dn), 64'(0));
    check("flush hi kept", 64'(hi), 64'h1234);
    check("flush lo kept", 64'(lo), 64'(lb));

    // start_i pulsed in cycle 5 of a running op is ignored.
    op = 2'b00; rs = 32'd3; rt = 32'hFFFFFFFE; start = 1'b1;
    @(posedge clk);
    dn = 0; dcyc = 0; hv = '0; lv = '0;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 5) begin start = 1'b1; op = 2'b11; rs = 32'd100; rt = 32'd3; end
      if (i == 6) start = 1'b0;
      if (done) begin
        dn++;
        if (dn == 1) begin dcyc = i; hv = hi; lv = lo; end
      end
    end
    check("ignored start single done", 64'(dn), 64'(1));
    check("ignored start latency", 64'(dcyc), 64'(W + 2));
    check("ignored start result", {hv, lv}, 64'hFFFFFFFF_FFFFFFFA);

    // Flush in the FIX cycle beats writeback.
    hb = hi; lb = lo;
    op = 2'b01; rs = 32'd2; rt = 32'd3; start = 1'b1;
    @(posedge clk);
    dn = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == W + 1) flush = 1'b1;
      if (i == W + 2) begin flush = 1'b0; check("fix flush busy", 64'(busy), 64'(0)); end
      if (done) dn++;
    end
    check("fix flush no done", 64'(dn), 64'(0));
    check("fix flush hi/lo kept", {hi, lo}, {hb, lb});

    // MTHI and flush in the same cycle as start: write lands, start taken, result overwrites.
    hi_we = 1'b1; wdata = 32'hCAFE0000; flush = 1'b1;
    issue(2'b11, 32'd100, 32'd7, '{32'd2, 32'd14, 1'b0, W + 2});
    wait_done("mthi+flush with start");
    check("mthi with start lands", 64'(hi_c1), 64'hCAFE0000);

    // Asynchronous reset mid-CALC, then MTLO idle vs busy.
    op = 2'b00; rs = 32'hFFFFFFFD; rt = 32'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async reset hi/lo", {hi, lo}, 64'h0);
    check("async reset flags", {61'b0, busy, done, dbz}, 64'h0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); lo_we = 1'b1; wdata = 32'h0000ABCD;
    @(negedge clk); lo_we = 1'b0;
    check("mtlo idle", 64'(lo), 64'hABCD);
    op = 2'b01; rs = 32'd2; rt = 32'd3; start = 1'b1;
    @(posedge clk);
    dcyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 3) begin lo_we = 1'b1; wdata = 32'h00005555; end
      if (i == 4) begin lo_we = 1'b0; check("mtlo busy ignored", 64'(lo), 64'hABCD); end
      if (done && dcyc == 0) begin dcyc = i; hv = hi; lv = lo; end
    end
    check("post-reset op latency", 64'(dcyc), 64'(W + 2));
    check("post-reset op result", {hv, lv}, 64'h00000000_00000006);

    // WIDTH=8 instance: MULT 0x80 * 0x80.
    @(negedge clk);
    op8 = 2'b00; rs8 = 8'h80; rt8 = 8'h80; start8 = 1'b1;
    @(posedge clk);
    dcyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) start8 = 1'b0;
      if (done8) begin dcyc = i; break; end
    end
    check("w8 latency", 64'(dcyc), 64'(10));
    check("w8 result", {48'b0, hi8, lo8}, 64'h4000);
    check("w8 busy/dbz", {62'b0, busy8, dbz8}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
